gty_rx_axis_framer: RTL
=======================

Name: gty_rx_axis_framer

Overview:
Second-generation GTY RX to AXI4-Stream bridge. It takes 64b/66b-decoded user data from a GTY lane, filters control and invalid sync-header blocks, and frames the data into packets of a runtime-programmable byte length, with a partial tkeep on the last beat. The GTY RX path cannot be back-pressured, so an internal FIFO absorbs downstream stalls. Admission control drops whole packets rather than truncating them. Sits between the GTY RX user interface and the AXI DMA S2MM stream input, with statistics counters for the register bank.

Parameters:
DATA_WIDTH, 64, GTY user data width in bits; multiple of 8; BPB = DATA_WIDTH/8.
FIFO_DEPTH, 16, FIFO entries (beats); power of 2, ≥ 2.
CNT_W, 16, width of the packet byte-length config.

Ports:
aclk  in  1  clock
aresetn  in  1  reset
cfg_enable  in  1  framing enable
cfg_pkt_bytes  in  CNT_W  packet length in bytes; latched at packet start
gty_rx_data  in  DATA_WIDTH  RX user data
gty_rx_valid  in  1  data beat valid (no backpressure)
gty_rx_header_valid  in  1  gty_rx_header qualifies this beat
gty_rx_header  in  2  sync header: 01 data, 10 control, 00/11 invalid
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  BPB  byte enables
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
fifo_level  out  clog2(FIFO_DEPTH)+1  beats held, not yet handshaked
stat_packets  out  32  packets forwarded (counted at tlast handshake)
stat_drops  out  32  packets dropped by admission control
stat_hdr_err  out  32  beats discarded for invalid header

Behaviour:
- aresetn is synchronous and active-low; aclk is the clock. Reset clears the FIFO, sets state IDLE, and sets m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0. All stats and fifo_level reset to 0.
- Beat classification, when gty_rx_valid=1:
  - gty_rx_header_valid=0 → data beat.
  - header 01 → data beat.
  - header 10 → control/idle; discarded, not counted.
  - header 00/11 → discarded; stat_hdr_err+1.
  - Discarded beats never advance packet counters.
- Length handling:
  - At packet start, L = cfg_pkt_bytes is clamped: 0 → BPB; > FIFO_DEPTH*BPB → FIFO_DEPTH*BPB.
  - beats = ceil(L/BPB); r = L mod BPB.
  - Last beat tkeep = low r bits set, or all ones if r=0. Other beats tkeep all ones.
- FSM:
  - IDLE: wait for cfg_enable=1 → WAIT.
  - WAIT: if cfg_enable=0 → IDLE. On a data beat, latch L and compute beats. If (FIFO_DEPTH - fifo_level) ≥ beats, write the beat and go to FWD; otherwise go to DROP and add 1 to stat_drops. The start beat is the packet's first beat either way. If beats=1, the start beat is also the last beat and the FSM stays in WAIT.
  - FWD: write each data beat; the beat counter reaches beats → tlast=1 on that entry → WAIT.
  - DROP: discard data beats until beats are consumed → WAIT.
- cfg_enable deasserted mid-packet: the current packet completes (FWD or DROP); then IDLE.
- Admission guarantees no FIFO overflow; a write to a full FIFO is a design error (simulation assertion).
- Latency: a beat sampled at edge N is presented on m_axis after edge N+1 when the FIFO is empty.
- Stream handshake:
  - Standard AXIS; tdata/tkeep/tlast are stable while tvalid=1 and tready=0.
  - Full-throughput (one beat per cycle) with simultaneous write and read.
  - With a simultaneous write and read, fifo_level is unchanged.
- Counter wrap: stats wrap at 2^32 silently. Internal pointers wrap modulo FIFO_DEPTH.
- Simultaneous events: a tlast handshake and a drop in the same cycle both increment their own counters.
- Reset mid-packet: partial packet data is lost; after reset, the first data beat starts a new packet.

Test Plan:
1. Basic framing: BPB=8, cfg_pkt_bytes=64, tready=1, 16 continuous data beats → 2 packets of 8 beats, tlast on beats 8 and 16, tkeep=FF, stat_packets=2.
2. Partial last beat: cfg_pkt_bytes=20 → 3 beats, last tkeep=0x0F.
3. Header filtering: header 10 and header 11 beats interleaved mid-packet → both discarded, packet still 8 beats, stat_hdr_err=1.
4. Backpressure and drop: FIFO_DEPTH=16, cfg_pkt_bytes=64, tready=0, 24 beats → packets 1 and 2 stored, fifo_level=16, packet 3 dropped, stat_drops=1. Then tready=1 → exactly 16 beats out, 2 tlasts.
5. Enable and reset: cfg_enable falls at beat 3 of 8 → packet completes with tlast, then input is ignored. aresetn pulsed mid-packet → tvalid=0 and fifo_level=0 next cycle; the next data beat begins a fresh packet.
6. Clamping: cfg_pkt_bytes=0 → 1-beat packets, tlast on every beat. cfg_pkt_bytes=1000 → 16-beat packets.

Source files
------------

// File: rtl/gty_rx_axis_framer_if.sv
// AXI4-Stream bundle carried from the framer to the DMA S2MM input.
interface gty_rx_axis_framer_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int BPB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [BPB-1:0]        tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/gty_rx_axis_framer.sv
// GTY RX (64b/66b decoded) to AXI4-Stream framer.
// Filters control/invalid sync-header blocks, cuts the data stream into
// packets of a programmable byte length and buffers them in a FIFO, since the
// GTY side cannot be stalled. Packets that would not fit are dropped whole.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | framing disabled, data beats ignored
// WAIT   | enabled, next data beat starts a packet (admit or drop)
// FWD    | admitted packet in progress, data beats written to FIFO
// DROP   | rejected packet in progress, data beats discarded
module gty_rx_axis_framer #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cfg_enable,
    input  logic [CNT_W-1:0]              cfg_pkt_bytes,
    input  logic [DATA_WIDTH-1:0]         gty_rx_data,
    input  logic                          gty_rx_valid,
    input  logic                          gty_rx_header_valid,
    input  logic [1:0]                    gty_rx_header,
    gty_rx_axis_framer_if.master          m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   stat_packets,
    output logic [31:0]                   stat_drops,
    output logic [31:0]                   stat_hdr_err
);
    localparam int BPB       = DATA_WIDTH / 8;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int LW        = AW + 1;
    localparam int MAX_BYTES = FIFO_DEPTH * BPB;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FWD, S_DROP} state_t;

    state_t          state_q;
    logic [LW-1:0]   beats_q;
    logic [LW-1:0]   cnt_q;
    logic [BPB-1:0]  keep_last_q;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [BPB-1:0]        mem_keep [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         mem_cnt_q;

    logic [DATA_WIDTH-1:0] tdata_q;
    logic [BPB-1:0]        tkeep_q;
    logic                  tlast_q;
    logic                  tvalid_q;

    logic            is_data_c, hdr_err_c, start_c, admit_c, drop_c;
    logic            wr_en_c, wr_last_c, pop_c;
    logic [31:0]     len_c, rem_c;
    logic [LW-1:0]   beats_c, cnt_inc_c;
    logic [BPB-1:0]  keep_c, wr_keep_c;

    assign is_data_c = gty_rx_valid && (!gty_rx_header_valid || gty_rx_header == 2'b01);
    assign hdr_err_c = gty_rx_valid && gty_rx_header_valid &&
                       (gty_rx_header == 2'b00 || gty_rx_header == 2'b11);

    // Clamp the requested length so a packet always fits in an empty FIFO.
    always_comb begin
        if (cfg_pkt_bytes == '0)
            len_c = 32'(BPB);
        else if (32'(cfg_pkt_bytes) > 32'(MAX_BYTES))
            len_c = 32'(MAX_BYTES);
        else
            len_c = 32'(cfg_pkt_bytes);
        beats_c = LW'((len_c + 32'(BPB - 1)) / 32'(BPB));
        rem_c   = len_c % 32'(BPB);
        keep_c  = (rem_c == 32'd0) ? {BPB{1'b1}} : ~({BPB{1'b1}} << rem_c);
    end

    assign fifo_level = mem_cnt_q + LW'(tvalid_q);
    assign cnt_inc_c  = cnt_q + LW'(1);
    assign start_c    = (state_q == S_WAIT) && cfg_enable && is_data_c;
    assign admit_c    = (LW'(FIFO_DEPTH) - fifo_level) >= beats_c;
    assign drop_c     = start_c && !admit_c;
    assign wr_en_c    = (start_c && admit_c) || (state_q == S_FWD && is_data_c);
    assign wr_last_c  = (state_q == S_WAIT) ? (beats_c == LW'(1)) : (cnt_inc_c == beats_q);
    assign wr_keep_c  = !wr_last_c ? {BPB{1'b1}} :
                        ((state_q == S_WAIT) ? keep_c : keep_last_q);
    assign pop_c      = (mem_cnt_q != '0) && (!tvalid_q || m_axis.tready);

    // Packet framing FSM: tracks beats of the current packet in FWD or DROP.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            beats_q     <= '0;
            cnt_q       <= '0;
            keep_last_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cfg_enable) state_q <= S_WAIT;
                S_WAIT: begin
                    if (!cfg_enable) begin
                        state_q <= S_IDLE;
                    end else if (is_data_c) begin
                        beats_q     <= beats_c;
                        keep_last_q <= keep_c;
                        cnt_q       <= LW'(1);
                        if (beats_c != LW'(1))
                            state_q <= admit_c ? S_FWD : S_DROP;
                    end
                end
                S_FWD, S_DROP: begin
                    if (is_data_c) begin
                        cnt_q <= cnt_inc_c;
                        if (cnt_inc_c == beats_q)
                            state_q <= cfg_enable ? S_WAIT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem_data[wr_ptr_q] <= gty_rx_data;
            mem_keep[wr_ptr_q] <= wr_keep_c;
            mem_last[wr_ptr_q] <= wr_last_c;
        end
    end

    // FIFO pointers and the registered AXIS output beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                tdata_q  <= mem_data[rd_ptr_q];
                tkeep_q  <= mem_keep[rd_ptr_q];
                tlast_q  <= mem_last[rd_ptr_q];
                tvalid_q <= 1'b1;
            end else if (m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            case ({wr_en_c, pop_c})
                2'b10:   mem_cnt_q <= mem_cnt_q + LW'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - LW'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
        end
    end

    // Statistics; all three wrap silently and may step in the same cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_packets <= '0;
            stat_drops   <= '0;
            stat_hdr_err <= '0;
        end else begin
            if (tvalid_q && m_axis.tready && tlast_q) stat_packets <= stat_packets + 32'd1;
            if (drop_c)    stat_drops   <= stat_drops + 32'd1;
            if (hdr_err_c) stat_hdr_err <= stat_hdr_err + 32'd1;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

    // Admission control must make a write into a full FIFO impossible.
    overflow_chk: assert property (@(posedge aclk) disable iff (!aresetn)
        !(wr_en_c && mem_cnt_q == LW'(FIFO_DEPTH) && !pop_c));

endmodule
